// File: rtl/led_fb.sv
// -----------------------------------------------------------------------------
// led_fb : double-buffered LED frame buffer
//
// Two banks (A and B) of ROWS x COLS pixels. The scan side reads the front
// bank with one cycle of latency; the host writes into the back bank. A swap
// exchanges the roles of the banks without copying any data. After reset an
// INIT sequence zeroes both banks. A CLEAR sequence zeroes only the back bank.
// A swap requested while a sequence runs (or together with a clear) is held
// pending and executes on the first idle cycle afterwards.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   wr_en      write strobe into the back bank (ignored while busy)
//   wr_row/col write address; out-of-range writes are dropped
//   wr_data    write pixel [stored][G][R][spare]
//   rd_row/col scan read address into the front bank
//   rd_data    pixel read, valid one cycle after the address (0 if out of range)
//   swap_req   request to exchange front and back banks
//   swap_ack   one-cycle pulse in the cycle after the swap takes effect
//   clr_req    request to clear the back bank (ignored while busy)
//   busy       high during INIT or CLEAR
//   front_sel  current front bank (0 = A, 1 = B)
// -----------------------------------------------------------------------------
module led_fb #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int PIX_W  = 4,
    parameter int ROW_AW = 3,
    parameter int COL_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ROW_AW-1:0] wr_row,
    input  logic [COL_AW-1:0] wr_col,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic [ROW_AW-1:0] rd_row,
    input  logic [COL_AW-1:0] rd_col,
    output logic [PIX_W-1:0]  rd_data,
    input  logic              swap_req,
    output logic              swap_ack,
    input  logic              clr_req,
    output logic              busy,
    output logic              front_sel
);

    localparam int AW    = ROW_AW + COL_AW;
    localparam int DEPTH = 1 << AW;

    // One extra bit so that ROWS == 2^ROW_AW is representable as a limit.
    localparam logic [ROW_AW:0]   ROW_LIM  = (ROW_AW + 1)'(ROWS);
    localparam logic [COL_AW:0]   COL_LIM  = (COL_AW + 1)'(COLS);
    localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(ROWS - 1);
    localparam logic [COL_AW-1:0] COL_LAST = COL_AW'(COLS - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t            state_reg,   state_next;
    logic [ROW_AW-1:0] cnt_row_reg, cnt_row_next;
    logic [COL_AW-1:0] cnt_col_reg, cnt_col_next;
    logic              pend_reg,    pend_next;
    logic              front_reg,   front_next;
    logic              ack_reg,     ack_next;

    logic              cnt_last;
    logic              wr_in_range;
    logic              rd_in_range;

    // Storage: address is {row, col}, so no multiplier is needed; the
    // entries beyond ROWS/COLS are simply never written or reported.
    logic [PIX_W-1:0]  bank_a [DEPTH];
    logic [PIX_W-1:0]  bank_b [DEPTH];
    logic [PIX_W-1:0]  bank_a_q;
    logic [PIX_W-1:0]  bank_b_q;

    logic              we_a;
    logic              we_b;
    logic [AW-1:0]     waddr;
    logic [PIX_W-1:0]  wdata;
    logic [AW-1:0]     raddr;

    logic              rd_valid_reg;
    logic              rd_sel_reg;

    assign cnt_last    = (cnt_row_reg == ROW_LAST) && (cnt_col_reg == COL_LAST);
    assign wr_in_range = ({1'b0, wr_row} < ROW_LIM) && ({1'b0, wr_col} < COL_LIM);
    assign rd_in_range = ({1'b0, rd_row} < ROW_LIM) && ({1'b0, rd_col} < COL_LIM);
    assign raddr       = {rd_row, rd_col};

    // ------------------------------------------------------------------
    // Control FSM: next state, visit counter, pending swap, bank select
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_row_next = cnt_row_reg;
        cnt_col_next = cnt_col_reg;
        pend_next    = pend_reg;
        front_next   = front_reg;
        ack_next     = 1'b0;
        case (state_reg)
            ST_INIT, ST_CLEAR: begin
                // Swaps requested mid-sequence collapse into one pending swap.
                if (swap_req) begin
                    pend_next = 1'b1;
                end
                if (cnt_last) begin
                    state_next   = ST_IDLE;
                    cnt_row_next = '0;
                    cnt_col_next = '0;
                end else if (cnt_col_reg == COL_LAST) begin
                    cnt_col_next = '0;
                    cnt_row_next = cnt_row_reg + ROW_AW'(1);
                end else begin
                    cnt_col_next = cnt_col_reg + COL_AW'(1);
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_next   = ST_CLEAR;
                    cnt_row_next = '0;
                    cnt_col_next = '0;
                    if (swap_req) begin
                        pend_next = 1'b1;
                    end
                end else if (swap_req || pend_reg) begin
                    front_next = ~front_reg;
                    ack_next   = 1'b1;
                    pend_next  = 1'b0;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_INIT;
            cnt_row_reg <= '0;
            cnt_col_reg <= '0;
            pend_reg    <= 1'b0;
            front_reg   <= 1'b0;
            ack_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_row_reg <= cnt_row_next;
            cnt_col_reg <= cnt_col_next;
            pend_reg    <= pend_next;
            front_reg   <= front_next;
            ack_reg     <= ack_next;
        end
    end

    // ------------------------------------------------------------------
    // Write port steering. The back bank is taken from the current
    // front_reg, so a write coinciding with a swap lands in the bank that
    // is about to become the front.
    // ------------------------------------------------------------------
    always_comb begin
        we_a  = 1'b0;
        we_b  = 1'b0;
        waddr = {wr_row, wr_col};
        wdata = wr_data;
        case (state_reg)
            ST_INIT: begin
                we_a  = 1'b1;
                we_b  = 1'b1;
                waddr = {cnt_row_reg, cnt_col_reg};
                wdata = '0;
            end
            ST_CLEAR: begin
                we_a  = front_reg;
                we_b  = ~front_reg;
                waddr = {cnt_row_reg, cnt_col_reg};
                wdata = '0;
            end
            ST_IDLE: begin
                if (wr_en && wr_in_range) begin
                    we_a = front_reg;
                    we_b = ~front_reg;
                end
            end
            default: begin
                we_a = 1'b0;
                we_b = 1'b0;
            end
        endcase
    end

    // Plain RAM processes (no reset) so each bank maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_a) begin
            bank_a[waddr] <= wdata;
        end
        bank_a_q <= bank_a[raddr];
    end

    always_ff @(posedge clk) begin
        if (we_b) begin
            bank_b[waddr] <= wdata;
        end
        bank_b_q <= bank_b[raddr];
    end

    // Read qualifier: remembers which bank was front when the address was
    // sampled, and forces 0 during INIT, for out-of-range addresses and
    // out of reset (bank contents are undefined until INIT finishes).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
            rd_sel_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= (state_reg != ST_INIT) && rd_in_range;
            rd_sel_reg   <= front_reg;
        end
    end

    assign rd_data   = rd_valid_reg ? (rd_sel_reg ? bank_b_q : bank_a_q) : '0;
    assign swap_ack  = ack_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign front_sel = front_reg;

endmodule
